fifo_stream_reader: RTL and testbench

- Consumer-side companion to the team's `fifo` block: drains the FIFO read port (fifo_empty / r_ready / data_out) and re-presents the data as a valid/ready stream master.
- Adds a 2-entry output buffer so the FIFO is decoupled from downstream backpressure.
- Frames the stream into bursts of BURST_LEN beats using m_tlast.
- Sits between `fifo` and any downstream stream sink (DMA or user logic).

---
 rtl/fifo_stream_reader.sv | 124 ++++++++++++
 tb/tb_fifo_stream_reader.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a first-word-fall-through FIFO read port into a
// 2-entry skid buffer and presents it as a valid/ready stream master, framing
// the beats into bursts of BURST_LEN with m_tlast. Dropping en closes the
// current partial burst on the last buffered word, then returns to IDLE.
module fifo_stream_reader #(
    parameter int WIDTH     = 32,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             r_ready,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tlast,
    output logic             busy,
    output logic             burst_done
);

    localparam int BCW = $clog2(BURST_LEN) + 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       count;
    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic [BCW-1:0]   beat_cnt;
    logic             pop;
    logic             hs;

    // Pop and handshake strobes; r_ready never looks at m_tready so the FIFO
    // side has no combinational path from the sink.
    always_comb begin
        r_ready  = (state == RUN) && (count != 2'd2) && !fifo_empty;
        pop      = r_ready;
        m_tvalid = (count != 2'd0);
        hs       = m_tvalid && m_tready;
        m_tdata  = slot0;
        // Gated by m_tvalid so an empty buffer never shows a stray tlast.
        m_tlast  = m_tvalid &&
                   ((beat_cnt == LAST_BEAT) || ((state == DRAIN) && (count == 2'd1)));
        busy     = (state != IDLE) || (count != 2'd0);
    end

    // Two-entry buffer: slot0 is always the oldest word; a pop and a
    // handshake on the same edge replace the single held word in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case ({pop, hs})
                2'b11: begin
                    slot0 <= fifo_data;
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        slot0 <= fifo_data;
                    end else begin
                        slot1 <= fifo_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Control FSM with burst beat counter and registered burst_done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= hs && m_tlast;
            if (hs) begin
                if (m_tlast) begin
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + BCW'(1);
                end
            end
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // An unterminated partial burst is abandoned here.
                    if (count == 2'd0) begin
                        state    <= IDLE;
                        beat_cnt <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO model feeding the DUT, a
// scoreboard of popped words checked at every handshake, a table of per-cycle
// expectations for the preloaded burst run, and hand-written corner cases.
module tb_fifo_stream_reader;

    localparam int WIDTH = 32;
    localparam int BL    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             r_ready;
    logic             m_tvalid;
    logic             m_tready;
    logic [WIDTH-1:0] m_tdata;
    logic             m_tlast;
    logic             busy;
    logic             burst_done;

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(WIDTH), .BURST_LEN(BL)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .r_ready    (r_ready),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .busy       (busy),
        .burst_done (burst_done)
    );

    typedef struct {
        logic        en;
        logic        rdy;
        logic        rr;
        logic        vld;
        logic [31:0] d;
        logic        last;
        logic        bd;
        logic        bsy;
    } vec_t;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] out_d[$];
    logic        out_l[$];
    int          pops;
    int          beat_m;
    int          written;
    int          emitted;
    logic        drain_seen;
    logic        exp_bd;
    logic        p_hs;
    logic        p_pop;
    logic        s_rr, s_vld, s_last, s_bd, s_busy;
    logic [31:0] s_data;
    vec_t        tbl[14];

    task automatic chkb(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic update_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 32'h0 : fifo_q[0];
    endtask

    task automatic load(input logic [31:0] w);
        fifo_q.push_back(w);
        written++;
        update_fifo();
    endtask

    // Sample outputs on the falling edge and run the generic checks.
    task automatic sample();
        logic [31:0] e;
        @(negedge clk);
        s_rr = r_ready; s_vld = m_tvalid; s_data = m_tdata;
        s_last = m_tlast; s_bd = burst_done; s_busy = busy;
        if (!s_busy) begin
            beat_m = 0;
            drain_seen = 1'b0;
        end
        chkb("burst_done", s_bd, exp_bd);
        chkb("r_ready_while_empty", s_rr & fifo_empty, 1'b0);
        p_pop  = s_rr && !fifo_empty;
        p_hs   = s_vld && m_tready;
        exp_bd = 1'b0;
        if (p_hs) begin
            chkb("sb_has_word", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chkw("sb_data", s_data, e);
            end
            if (beat_m == BL - 1) chkb("tlast_on_full_burst", s_last, 1'b1);
            else                  chkb("tlast_illegal", s_last && !drain_seen, 1'b0);
            out_d.push_back(s_data);
            out_l.push_back(s_last);
            emitted++;
            if (s_last) beat_m = 0;
            else        beat_m++;
            exp_bd = s_last;
        end
    endtask

    // Cross the rising edge and update the FIFO model / scoreboard.
    task automatic advance();
        @(posedge clk);
        if (!en) drain_seen = 1'b1;
        if (p_pop) begin
            exp_q.push_back(fifo_q.pop_front());
            pops++;
        end
        #1;
        update_fifo();
    endtask

    task automatic clear_model();
        exp_q.delete(); out_d.delete(); out_l.delete();
        pops = 0; beat_m = 0; drain_seen = 1'b0; exp_bd = 1'b0;
        p_hs = 1'b0; p_pop = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; m_tready = 1'b0;
        fifo_q.delete();
        clear_model();
        written = 0; emitted = 0;
        update_fifo();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run_until(input int n, input int limit, input string name);
        for (int i = 0; i < limit && out_d.size() < n; i++) begin
            sample();
            advance();
        end
        chkw(name, 32'(out_d.size()), 32'(n));
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            sample();
            done = !s_busy;
            advance();
        end
        chkb(name, done, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // en, rdy | r_ready, tvalid, tdata, tlast, burst_done, busy
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd2, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd3, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd4, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd5, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd6, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'd7, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0};

        // Reset state
        reset = 1'b1; en = 1'b0; m_tready = 1'b0;
        written = 0; emitted = 0;
        clear_model();
        update_fifo();
        #2;
        chkb("rst_r_ready", r_ready, 1'b0);
        chkb("rst_m_tvalid", m_tvalid, 1'b0);
        chkw("rst_m_tdata", m_tdata, 32'h0);
        chkb("rst_m_tlast", m_tlast, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_burst_done", burst_done, 1'b0);

        // Preloaded 0..7, full-rate table run
        do_reset();
        for (int i = 0; i < 8; i++) load(32'(i));
        for (int i = 0; i < 14; i++) begin
            en = tbl[i].en;
            m_tready = tbl[i].rdy;
            sample();
            chkb($sformatf("t1_r_ready[%0d]", i), s_rr, tbl[i].rr);
            chkb($sformatf("t1_tvalid[%0d]", i), s_vld, tbl[i].vld);
            if (tbl[i].vld) chkw($sformatf("t1_tdata[%0d]", i), s_data, tbl[i].d);
            chkb($sformatf("t1_tlast[%0d]", i), s_last, tbl[i].last);
            chkb($sformatf("t1_burst_done[%0d]", i), s_bd, tbl[i].bd);
            chkb($sformatf("t1_busy[%0d]", i), s_busy, tbl[i].bsy);
            advance();
        end

        // Sink stalled: exactly two pops, head held, then full drain in order
        do_reset();
        for (int i = 0; i < 6; i++) load(32'h10 + 32'(i));
        en = 1'b1; m_tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sample();
            advance();
        end
        chkw("t2_pops_stalled", 32'(pops), 32'd2);
        sample();
        chkb("t2_r_ready_stalled", s_rr, 1'b0);
        chkb("t2_tvalid_stalled", s_vld, 1'b1);
        chkw("t2_tdata_held", s_data, 32'h10);
        advance();
        m_tready = 1'b1;
        run_until(6, 30, "t2_beats");
        for (int i = 0; i < 6 && i < out_d.size(); i++)
            chkw($sformatf("t2_order[%0d]", i), out_d[i], 32'h10 + 32'(i));
        en = 1'b0;
        wait_idle("t2_idle");

        // Disable after two beats closes the burst on the third word
        do_reset();
        load(32'hA); load(32'hB); load(32'hC);
        en = 1'b1; m_tready = 1'b1;
        for (int i = 0; i < 20 && out_d.size() < 3; i++) begin
            sample();
            if (out_d.size() == 2) en = 1'b0;
            advance();
        end
        chkw("t3_beats", 32'(out_d.size()), 32'd3);
        if (out_d.size() == 3) begin
            chkw("t3_last_word", out_d[2], 32'hC);
            chkb("t3_last_tlast", out_l[2], 1'b1);
            chkb("t3_first_tlast", out_l[0] | out_l[1], 1'b0);
        end
        wait_idle("t3_idle");
        for (int i = 0; i < 4; i++) load(32'hD + 32'(i));
        en = 1'b1;
        run_until(7, 30, "t3_restart_beats");
        if (out_d.size() == 7) begin
            chkb("t3_restart_b0", out_l[3], 1'b0);
            chkb("t3_restart_b1", out_l[4], 1'b0);
            chkb("t3_restart_b2", out_l[5], 1'b0);
            chkb("t3_restart_b3", out_l[6], 1'b1);
        end
        en = 1'b0;
        wait_idle("t3_idle2");

        // FIFO runs dry mid-burst; burst resumes when data returns
        do_reset();
        load(32'h20); load(32'h21);
        en = 1'b1; m_tready = 1'b1;
        run_until(2, 20, "t4_first_beats");
        for (int i = 0; i < 5; i++) begin
            sample();
            advance();
        end
        sample();
        chkb("t4_tvalid_dry", s_vld, 1'b0);
        chkb("t4_busy_dry", s_busy, 1'b1);
        advance();
        load(32'h22); load(32'h23);
        run_until(4, 20, "t4_all_beats");
        if (out_d.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chkw($sformatf("t4_data[%0d]", i), out_d[i], 32'h20 + 32'(i));
                chkb($sformatf("t4_tlast[%0d]", i), out_l[i], i == 3);
            end
        end
        en = 1'b0;
        wait_idle("t4_idle");

        // Asynchronous reset with a full buffer
        do_reset();
        for (int i = 0; i < 8; i++) load(32'h30 + 32'(i));
        en = 1'b1; m_tready = 1'b0;
        for (int i = 0; i < 20 && pops < 2; i++) begin
            sample();
            advance();
        end
        chkw("t5_pops", 32'(pops), 32'd2);
        sample();
        chkb("t5_tvalid_full", s_vld, 1'b1);
        reset = 1'b1;
        #1;
        chkb("t5_async_tvalid", m_tvalid, 1'b0);
        chkw("t5_async_tdata", m_tdata, 32'h0);
        chkb("t5_async_tlast", m_tlast, 1'b0);
        chkb("t5_async_busy", busy, 1'b0);
        chkb("t5_async_r_ready", r_ready, 1'b0);
        chkb("t5_async_burst_done", burst_done, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        clear_model();
        update_fifo();
        m_tready = 1'b1;
        run_until(4, 20, "t5_new_beats");
        if (out_d.size() == 4) begin
            chkw("t5_first_word", out_d[0], 32'h32);
            for (int i = 0; i < 4; i++)
                chkb($sformatf("t5_tlast[%0d]", i), out_l[i], i == 3);
        end
        en = 1'b0;
        wait_idle("t5_idle");

        // Random traffic
        do_reset();
        en = 1'b1;
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 16) load($urandom);
            m_tready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 11) == 0) en = !en;
            sample();
            advance();
        end
        en = 1'b1; m_tready = 1'b1;
        for (int i = 0; i < 300 && (fifo_q.size() > 0 || exp_q.size() > 0); i++) begin
            sample();
            advance();
        end
        en = 1'b0;
        wait_idle("rnd_idle");
        chkw("rnd_fifo_left", 32'(fifo_q.size()), 32'd0);
        chkw("rnd_sb_left", 32'(exp_q.size()), 32'd0);
        chkw("rnd_count", 32'(emitted), 32'(written));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
